// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: computes A - B - borrow_in over WORDS digits of WIDTH bits,
// least-significant digit first, with valid/ready handshakes on both sides.
module serial_subtractor #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [WIDTH*WORDS-1:0]   i_a,
    input  logic [WIDTH*WORDS-1:0]   i_b,
    input  logic                     i_borr,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [WIDTH*WORDS-1:0]   o_sub,
    output logic                     o_borr,
    output logic                     o_zero
);

    localparam int TOTAL = WIDTH * WORDS;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(WORDS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borr_q, borr_d;
    logic [TOTAL-1:0] a_q, a_d;
    logic [TOTAL-1:0] b_q, b_d;
    logic [TOTAL-1:0] res_q, res_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] a_digits [WORDS];
    logic [WIDTH-1:0] b_digits [WORDS];
    logic [WIDTH-1:0] a_dig;
    logic [WIDTH-1:0] b_dig;
    logic [WIDTH:0]   diff;

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_digits
            assign a_digits[gi] = a_q[gi*WIDTH +: WIDTH];
            assign b_digits[gi] = b_q[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Select the digit pair addressed by the counter.
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (cnt_q == CW'(i)) begin
                a_dig = a_digits[i];
                b_dig = b_digits[i];
            end
        end
    end

    // One extra bit: the top bit of the difference is the digit borrow-out.
    assign diff = {1'b0, a_dig} - {1'b0, b_dig} - {{WIDTH{1'b0}}, borr_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        borr_d  = borr_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    borr_d  = i_borr;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < WORDS; i++) begin
                    if (cnt_q == CW'(i)) begin
                        res_d[i*WIDTH +: WIDTH] = diff[WIDTH-1:0];
                    end
                end
                borr_d = diff[WIDTH];
                if (cnt_q == LAST_DIGIT) begin
                    zero_d  = ~|res_d;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            borr_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            borr_q  <= borr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    assign o_ready = (state_q == ST_IDLE);
    assign o_valid = (state_q == ST_DONE);
    assign o_sub   = res_q;
    assign o_borr  = borr_q;
    assign o_zero  = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4, WORDS=4) with directed vectors.
module tb_serial_subtractor;

    localparam int WIDTH = 4;
    localparam int WORDS = 4;
    localparam int TOTAL = WIDTH * WORDS;

    typedef struct {
        logic [TOTAL-1:0] sub;
        logic             borr;
        logic             zero;
    } exp_t;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [TOTAL-1:0] i_a = '0;
    logic [TOTAL-1:0] i_b = '0;
    logic             i_borr = 1'b0;
    logic             o_valid;
    logic             i_ready = 1'b1;
    logic [TOTAL-1:0] o_sub;
    logic             o_borr;
    logic             o_zero;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    serial_subtractor #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_a    (i_a),
        .i_b    (i_b),
        .i_borr (i_borr),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_sub  (o_sub),
        .o_borr (o_borr),
        .o_zero (o_zero)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops one expected result per output handshake.
    always @(negedge i_clk) begin
        if (!i_rst && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'(o_sub), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("txn result sub=0x%04h borr=%0b zero=%0b (expect 0x%04h %0b %0b)",
                         o_sub, o_borr, o_zero, e.sub, e.borr, e.zero);
                chk("result_sub",  32'(o_sub),  32'(e.sub));
                chk("result_borr", 32'(o_borr), 32'(e.borr));
                chk("result_zero", 32'(o_zero), 32'(e.zero));
            end
        end
    end

    // Issue one operand set, check handshake timing; leaves the DUT in DONE
    // (rdy=0) or back in IDLE (rdy=1).
    task automatic run_txn(input logic [TOTAL-1:0] a, input logic [TOTAL-1:0] b,
                           input logic borr, input logic [TOTAL-1:0] esub,
                           input logic eborr, input logic ezero, input logic rdy);
        exp_t e;
        e.sub = esub; e.borr = eborr; e.zero = ezero;
        exp_q.push_back(e);
        i_ready = rdy;
        i_a = a; i_b = b; i_borr = borr; i_valid = 1'b1;
        chk("ready_before_accept", 32'(o_ready), 32'd1);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_a = ~a; i_b = ~b; i_borr = ~borr;
        for (int i = 0; i < WORDS; i++) begin
            chk("run_valid_low", 32'(o_valid), 32'd0);
            chk("run_ready_low", 32'(o_ready), 32'd0);
            @(posedge i_clk); #1;
        end
        chk("done_valid_high", 32'(o_valid), 32'd1);
        chk("done_ready_low",  32'(o_ready), 32'd0);
        if (rdy) begin
            @(posedge i_clk); #1;
            chk("idle_ready_high", 32'(o_ready), 32'd1);
            chk("idle_valid_low",  32'(o_valid), 32'd0);
        end
    endtask

    initial begin
        logic [TOTAL-1:0] held;
        exp_t e;

        @(posedge i_clk); #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        chk("post_rst_valid", 32'(o_valid), 32'd0);
        chk("post_rst_sub",   32'(o_sub),   32'h0000);
        chk("post_rst_borr",  32'(o_borr),  32'd0);
        chk("post_rst_zero",  32'(o_zero),  32'd0);
        chk("post_rst_ready", 32'(o_ready), 32'd1);

        run_txn(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
        run_txn(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        run_txn(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        run_txn(16'h0001, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1);

        // Backpressure: result held in DONE while new operands wait.
        run_txn(16'h5678, 16'h1234, 1'b0, 16'h4444, 1'b0, 1'b0, 1'b0);
        held = o_sub;
        e.sub = 16'hF000; e.borr = 1'b1; e.zero = 1'b0;
        exp_q.push_back(e);
        i_a = 16'h1000; i_b = 16'h2000; i_borr = 1'b0; i_valid = 1'b1;
        repeat (3) begin
            @(posedge i_clk); #1;
            chk("bp_sub_stable", 32'(o_sub),   32'(held));
            chk("bp_valid",      32'(o_valid), 32'd1);
            chk("bp_ready_low",  32'(o_ready), 32'd0);
        end
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        chk("bp_idle_ready", 32'(o_ready), 32'd1);
        chk("bp_idle_valid", 32'(o_valid), 32'd0);
        @(posedge i_clk); #1;
        chk("bp_accepted", 32'(o_ready), 32'd0);
        i_valid = 1'b0; i_a = 16'hAAAA; i_b = 16'h5555;
        repeat (WORDS - 1) begin @(posedge i_clk); #1; end
        chk("bp_valid_not_early", 32'(o_valid), 32'd0);
        @(posedge i_clk); #1;
        chk("bp_valid_on_time", 32'(o_valid), 32'd1);
        @(posedge i_clk); #1;

        // Asynchronous reset in the second RUN cycle.
        i_a = 16'h1230; i_b = 16'h0001; i_borr = 1'b0; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(posedge i_clk); #1;
        chk("partial_sub",  32'(o_sub),  32'h000F);
        chk("partial_borr", 32'(o_borr), 32'd1);
        #2 i_rst = 1'b1;
        #1;
        chk("abort_valid", 32'(o_valid), 32'd0);
        chk("abort_sub",   32'(o_sub),   32'h0000);
        chk("abort_borr",  32'(o_borr),  32'd0);
        chk("abort_ready", 32'(o_ready), 32'd1);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        run_txn(16'hFFFF, 16'h8000, 1'b1, 16'h7FFE, 1'b0, 1'b0, 1'b1);
        run_txn(16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge i_clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
